// File: rtl/dac_spi_arbiter.sv
// -----------------------------------------------------------------------------
// dac_spi_arbiter
//   Shares one serial 16-bit audio DAC between two tone-sample requesters
//   (channel A and channel B). Requests are granted round-robin through
//   valid/ready handshakes. Each granted sample goes out as one 24-bit SPI
//   frame {6'b0, pd_mode, sample}, MSB first. The last fully sent sample is
//   mirrored on a parallel monitor output.
//
// Parameters
//   CLK_DIV   clock_clk cycles per SPI clock half-period (>= 1)
//   SYNC_GAP  minimum clock_clk cycles spi_sync stays high between frames (>= 1)
//
// Ports
//   clock_clk      system clock, rising edge
//   reset_reset_n  asynchronous active-low reset
//   a_valid/a_data/a_ready   channel A sample handshake
//   b_valid/b_data/b_ready   channel B sample handshake
//   pd_mode        DAC power-down bits, captured with the sample
//   spi_data       serial data, MSB first
//   spi_clk        serial clock, idles high, DAC samples on falling edge
//   spi_sync       frame sync, active low
//   busy           high whenever the arbiter is not idle
//   last_grant_b   0 = A granted last, 1 = B granted last
//   dac_out_data   last fully transmitted sample
// -----------------------------------------------------------------------------
module dac_spi_arbiter #(
   parameter int CLK_DIV  = 2,
   parameter int SYNC_GAP = 4
) (
   input  logic        clock_clk,
   input  logic        reset_reset_n,
   input  logic        a_valid,
   input  logic [15:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [15:0] b_data,
   output logic        b_ready,
   input  logic [1:0]  pd_mode,
   output logic        spi_data,
   output logic        spi_clk,
   output logic        spi_sync,
   output logic        busy,
   output logic        last_grant_b,
   output logic [15:0] dac_out_data
);

   localparam int PW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
   localparam int GW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t        r_state,  w_state_next;
   // Bit 23 of the frame goes straight to spi_data at acceptance, so only the
   // remaining 23 bits need to be held here.
   logic [22:0]   r_shift,  w_shift_next;
   logic [4:0]    r_bit,    w_bit_next;
   logic [PW-1:0] r_phase,  w_phase_next;
   logic          r_low,    w_low_next;     // 0 = spi_clk high half, 1 = low half
   logic [GW-1:0] r_gap,    w_gap_next;
   logic          r_last_b, w_last_b_next;
   logic [15:0]   r_sample, w_sample_next;
   logic [15:0]   r_dac,    w_dac_next;
   logic          r_sync,   w_sync_next;
   logic          r_sclk,   w_sclk_next;
   logic          r_sdata,  w_sdata_next;

   logic          w_idle;
   logic          w_grant_b;
   logic          w_accept;
   logic [15:0]   w_data;
   logic [23:0]   w_load;

   // Round-robin: on a tie, the channel that did not win last time goes next.
   assign w_idle    = (r_state == IDLE);
   assign w_grant_b = b_valid & (~a_valid | ~r_last_b);
   assign a_ready   = w_idle & a_valid & ~w_grant_b;
   assign b_ready   = w_idle & w_grant_b;
   assign w_accept  = a_ready | b_ready;
   assign w_data    = w_grant_b ? b_data : a_data;
   assign w_load    = {6'b0, pd_mode, w_data};

   always_comb begin
      w_state_next  = r_state;
      w_shift_next  = r_shift;
      w_bit_next    = r_bit;
      w_phase_next  = r_phase;
      w_low_next    = r_low;
      w_gap_next    = r_gap;
      w_last_b_next = r_last_b;
      w_sample_next = r_sample;
      w_dac_next    = r_dac;
      w_sync_next   = r_sync;
      w_sclk_next   = r_sclk;
      w_sdata_next  = r_sdata;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next  = SHIFT;
               w_shift_next  = w_load[22:0];
               w_bit_next    = 5'd23;
               w_phase_next  = '0;
               w_low_next    = 1'b0;
               w_last_b_next = w_grant_b;
               w_sample_next = w_data;
               w_sync_next   = 1'b0;
               w_sclk_next   = 1'b1;
               w_sdata_next  = w_load[23];
            end
         end

         SHIFT: begin
            if (r_phase != PH_LAST) begin
               w_phase_next = r_phase + 1'b1;
            end else begin
               w_phase_next = '0;
               if (!r_low) begin
                  w_low_next  = 1'b1;
                  w_sclk_next = 1'b0;
               end else if (r_bit == 5'd0) begin
                  // Low half of bit 0 done: close the frame and publish it.
                  w_state_next = GAP;
                  w_gap_next   = '0;
                  w_sync_next  = 1'b1;
                  w_sclk_next  = 1'b1;
                  w_sdata_next = 1'b0;
                  w_dac_next   = r_sample;
               end else begin
                  // Next bit starts while spi_clk is high.
                  w_low_next   = 1'b0;
                  w_bit_next   = r_bit - 5'd1;
                  w_shift_next = {r_shift[21:0], 1'b0};
                  w_sclk_next  = 1'b1;
                  w_sdata_next = r_shift[22];
               end
            end
         end

         GAP: begin
            if (r_gap == GAP_LAST) begin
               w_state_next = IDLE;
            end else begin
               w_gap_next = r_gap + 1'b1;
            end
         end

         default: w_state_next = IDLE;
      endcase
   end

   // Pin levels are registered so spi_* never glitch; reset forces the idle
   // levels immediately, which makes the DAC discard a half-sent frame.
   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_bit    <= '0;
         r_phase  <= '0;
         r_low    <= 1'b0;
         r_gap    <= '0;
         r_last_b <= 1'b1;
         r_sample <= '0;
         r_dac    <= '0;
         r_sync   <= 1'b1;
         r_sclk   <= 1'b1;
         r_sdata  <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_shift  <= w_shift_next;
         r_bit    <= w_bit_next;
         r_phase  <= w_phase_next;
         r_low    <= w_low_next;
         r_gap    <= w_gap_next;
         r_last_b <= w_last_b_next;
         r_sample <= w_sample_next;
         r_dac    <= w_dac_next;
         r_sync   <= w_sync_next;
         r_sclk   <= w_sclk_next;
         r_sdata  <= w_sdata_next;
      end
   end

   assign spi_data     = r_sdata;
   assign spi_clk      = r_sclk;
   assign spi_sync     = r_sync;
   assign busy         = ~w_idle;
   assign last_grant_b = r_last_b;
   assign dac_out_data = r_dac;

endmodule
